// File: rtl/lcd_timing_gen_if.sv
// Bundle between the raster timing generator and the downstream pixel stage.
// Lock/enable flow into the generator; sync, enable and coordinates flow out.
interface lcd_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          pll_locked;
  logic          enable;
  logic          hsync_n;
  logic          vsync_n;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          disp_on;

  modport master (
    input  pll_locked, enable,
    output hsync_n, vsync_n, de, x, y, line_start, frame_start, disp_on
  );

  modport slave (
    output pll_locked, enable,
    input  hsync_n, vsync_n, de, x, y, line_start, frame_start, disp_on
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parallel RGB LCD raster timing generator: waits for a settled PLL lock, then
// drives hsync/vsync/de and pixel coordinates, blanking whenever lock or enable drops.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FRONT  = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BACK   = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BACK   = 2,
  parameter int unsigned SETTLE   = 1024,
  parameter int unsigned CW       = 10
) (
  input logic              clk,
  input logic              reset_n,
  lcd_timing_gen_if.master lcd
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  // Last settle count before RUN; the increment from here reaches SETTLE-1.
  localparam logic [SW-1:0] SETTLE_GO = SW'(SETTLE - 2);

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_too_small
    $error("lcd_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (SETTLE < 1) begin : g_settle_zero
    $error("lcd_timing_gen: SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          go;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          disp_q, disp_d;

  assign go = lcd.pll_locked && lcd.enable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  // Counters default to zero so every exit path (and RUN entry) starts clean.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    h_d      = '0;
    v_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = (SETTLE == 1) ? StRun : StSettle;
      end
      StSettle: begin
        if (!go) begin
          state_d = StIdle;
        end else begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SETTLE_GO) state_d = StRun;
        end
      end
      StRun: begin
        if (!go) begin
          state_d = StIdle;
        end else if (h_q == H_MAX) begin
          h_d = '0;
          v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
          v_d = v_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decode of the current counters; registered below so outputs lag by one clock.
  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    disp_d  = 1'b0;
    if (state_q == StRun) begin
      de_d    = (h_q < H_ACT) && (v_q < V_ACT);
      hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
      vsync_d = !((v_q >= VS_START) && (v_q < VS_END));
      if (de_d) begin
        x_d = h_q;
        y_d = v_q;
      end
      ls_d   = de_d && (h_q == '0);
      fs_d   = ls_d && (v_q == '0);
      disp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      disp_q  <= disp_d;
    end
  end

  assign lcd.hsync_n     = hsync_q;
  assign lcd.vsync_n     = vsync_q;
  assign lcd.de          = de_q;
  assign lcd.x           = x_q;
  assign lcd.y           = y_q;
  assign lcd.line_start  = ls_q;
  assign lcd.frame_start = fs_q;
  assign lcd.disp_on     = disp_q;

endmodule
